prog_clk_divider: RTL and testbench

//  Runtime-programmable integer clock divider with 50% duty for both even and odd ratios.

---
 rtl/prog_clk_divider.sv | 120 ++++++++++++
 tb/tb_prog_clk_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// A posedge flop (pos_q) carries the high phase; for odd ratios it is ANDed with a
// half-cycle-delayed copy (neg_q) so that the high time shrinks by half a clk period.
// Ratio changes are applied only at period boundaries, so clk_out never emits a runt pulse.
module prog_clk_divider #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             running,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
  localparam logic [CNT_W:0]   HalfOne = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             run_q, run_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic             neg_q;
  logic             even_q;

  logic             wrap;
  logic             load_ok;
  logic             apply;
  logic [CNT_W:0]   half;

  // Next-state logic for the period counter, run flag, divisor staging and pulses.
  always_comb begin
    // One extra bit so that div_q = 2^CNT_W-1 does not overflow when rounding up.
    half       = ({1'b0, div_q} + HalfOne) >> 1;
    wrap       = run_q && (cnt_q == (div_q - CntOne));
    load_ok    = div_load && (div_in >= MinDiv);
    // Pending divisor lands at the period wrap while running, or at once when idle.
    apply      = pend_vld_q && (run_q ? wrap : 1'b1);

    cnt_d      = '0;
    if (run_q && !wrap) begin
      cnt_d = cnt_q + CntOne;
    end

    run_d      = run_q;
    if (!run_q) begin
      run_d = en;
    end else if (wrap && !en) begin
      run_d = 1'b0;
    end

    // pos_q follows cnt by one cycle: high for the H cycles after cnt passes 0..H-1.
    pos_d      = run_q && ({1'b0, cnt_q} < half);
    tick_d     = run_q && (cnt_q == '0);
    err_d      = div_load && (div_in < MinDiv);

    div_d      = apply ? pend_q : div_q;
    pend_d     = load_ok ? div_in : pend_q;
    pend_vld_d = pend_vld_q;
    if (load_ok) begin
      pend_vld_d = 1'b1;
    end else if (apply) begin
      pend_vld_d = 1'b0;
    end
  end

  // Posedge state with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= DefDiv;
      pend_q     <= DefDiv;
      pend_vld_q <= 1'b0;
      run_q      <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      run_q      <= run_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  // Half-cycle flops: neg_q delays pos_q by half a clk; even_q bypasses it for even ratios.
  // div_q only changes at the start of a cnt==0 cycle, where pos_q is already low, so the
  // mode flop always updates while the output AND is held at 0 by pos_q.
  always_ff @(negedge clk) begin
    if (reset) begin
      neg_q  <= 1'b0;
      even_q <= 1'b0;
    end else begin
      neg_q  <= pos_q;
      even_q <= ~div_q[0];
    end
  end

  assign clk_out = pos_q & (neg_q | even_q);
  assign tick    = tick_q;
  assign div_cur = div_q;
  assign running = run_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: the stimulus pushes the divisor expected for each coming
// clk_out period; a monitor pops one entry per tick and checks div_cur, tick spacing and
// the clk_out high width measured in half clk periods.
module tb_prog_clk_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       div_load = 1'b0;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       running;
  logic       cfg_err;

  prog_clk_divider #(
    .CNT_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .running  (running),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  // Set by stimulus when continuity is broken (start, stop, reset); cleared by the monitor.
  bit brk = 1'b1;

  int m_cyc = 0;
  int m_last = 0;
  int m_prev_d = 0;
  int m_cur_d = 0;
  int m_hi = 0;
  int m_d = 0;
  bit m_out_prev = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic track_out();
    if (clk_out === 1'b1) begin
      m_hi++;
    end else if (m_out_prev) begin
      if (!brk) check("high_halves", m_hi, m_cur_d);
      m_hi = 0;
    end
    m_out_prev = (clk_out === 1'b1);
  endtask

  // Monitor: samples 1 time unit after each clock edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      m_cyc++;
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          m_d = exp_q.pop_front();
          check("div_cur_at_tick", int'(div_cur), m_d);
          if (!brk) check("tick_spacing", m_cyc - m_last, m_prev_d);
          brk      = 1'b0;
          m_prev_d = m_d;
          m_cur_d  = m_d;
          m_last   = m_cyc;
        end
      end
      track_out();
      @(negedge clk);
      #1;
      track_out();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input int n);
    repeat (n) exp_q.push_back(d);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_div(input int v);
    div_in   = 8'(v);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  initial begin : stim
    int quiet;
    // Reset for 3 cycles.
    repeat (3) step();
    check("reset_clk_out", clk_out, 0);
    check("reset_div_cur", div_cur, 2);
    check("reset_running", running, 0);
    check("reset_tick", tick, 0);
    check("reset_cfg_err", cfg_err, 0);
    reset = 1'b0;

    // Default ratio 2.
    en = 1'b1;
    push(2, 4);
    drain(50);

    // Load 3 at the wrap edge of a /2 period: one more /2 period, then /3.
    push(2, 1);
    push(3, 4);
    load_div(3);
    drain(60);

    // 7 then 10 inside one /3 period: only 10 ever reaches div_cur.
    push(3, 1);
    push(10, 3);
    step();
    step();
    load_div(7);
    load_div(10);
    drain(100);

    // Ratio 6, drop en at cnt=1: period completes, then clean stop.
    push(6, 1);
    load_div(6);
    drain(50);
    en = 1'b0;
    repeat (4) step();
    check("running_mid_stop", running, 1);
    step();
    check("running_after_stop", running, 0);
    check("clk_out_after_stop", clk_out, 0);
    quiet = 0;
    repeat (12) begin
      step();
      if (clk_out !== 1'b0) quiet++;
      if (running !== 1'b0) quiet++;
    end
    check("stopped_quiet", quiet, 0);
    brk = 1'b1;

    // Restart and reject illegal divisors.
    en = 1'b1;
    push(6, 3);
    load_div(1);
    check("running_restart", running, 1);
    check("cfg_err_div1", cfg_err, 1);
    step();
    check("cfg_err_clear1", cfg_err, 0);
    load_div(0);
    check("cfg_err_div0", cfg_err, 1);
    step();
    check("cfg_err_clear0", cfg_err, 0);
    drain(60);

    // Maximum ratio 255, reset at cnt=100 inside the high phase.
    push(255, 1);
    load_div(255);
    drain(60);
    repeat (99) step();
    check("high_before_reset", clk_out, 1);
    brk   = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("clk_out_reset_negedge", clk_out, 0);
    step();
    check("reset2_div_cur", div_cur, 2);
    check("reset2_running", running, 0);
    check("reset2_tick", tick, 0);
    check("reset2_clk_out", clk_out, 0);
    step();
    reset = 1'b0;
    push(2, 4);
    drain(60);
    check("running_final", running, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
